// File: rtl/time_set_ctrl.sv
// time_set_ctrl: push-button front end and set-time FSM for the digital clock.
// Debounces MODE/INC/DEC, lets the user edit hours then minutes, and on commit
// pulses load for one cycle with the edited hh:mm and seconds = 0.
// Optional feature macro: AUTO_REPEAT_EN (held INC/DEC auto-repeats).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RUN     | clock running, edit values held, waiting for MODE
// S_SET_HR  | editing hours (blink hours field)
// S_SET_MIN | editing minutes (blink minutes field)
// S_COMMIT  | single cycle with load high, always returns to S_RUN

module time_set_ctrl #(
   parameter int DB_CYCLES          = 2_000_000,
   parameter int TIMEOUT_CYCLES     = 1_000_000_000,
   parameter int REPEAT_DLY_CYCLES  = 50_000_000,
   parameter int REPEAT_RATE_CYCLES = 10_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [4:0] cur_hrs,
   input  logic [5:0] cur_min,
   output logic       load,
   output logic [4:0] load_hrs,
   output logic [5:0] load_min,
   output logic [5:0] load_sec,
   output logic       set_active,
   output logic [1:0] blink_sel
);

   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DB_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DLY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DLY_CYCLES : REPEAT_RATE_CYCLES;
   localparam int RP_W = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
   localparam logic [RP_W-1:0] RP_DLY_RELOAD  = RP_W'(REPEAT_DLY_CYCLES - 1);
   localparam logic [RP_W-1:0] RP_RATE_RELOAD = RP_W'(REPEAT_RATE_CYCLES - 1);
`endif

   // Every counter reloads with N-1, so zero-length settings cannot be built.
   if (DB_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
       REPEAT_DLY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_cfg
      $error("time_set_ctrl: cycle-count parameters must be >= 1");
   end

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_SET_HR  = 2'd1,
      S_SET_MIN = 2'd2,
      S_COMMIT  = 2'd3
   } state_t;

   // bit 0 = mode, bit 1 = inc, bit 2 = dec
   logic [2:0] btn_raw;
   logic [2:0] pulse;

   assign btn_raw  = {btn_dec, btn_inc, btn_mode};
   assign load_sec = 6'd0;

   for (genvar i = 0; i < 3; i++) begin : g_btn
      logic            sync_1;
      logic            sync_2;
      logic            lvl;
      logic            lvl_d;
      logic            prs;
      logic [DB_W-1:0] db_cnt;

      // Synchronise, debounce with a restartable down-counter, register the rising edge.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            lvl    <= 1'b0;
            lvl_d  <= 1'b0;
            prs    <= 1'b0;
            db_cnt <= '0;
         end else begin
            sync_1 <= btn_raw[i];
            sync_2 <= sync_1;
            lvl_d  <= lvl;
            prs    <= lvl & ~lvl_d;
            if (sync_2 == lvl) begin
               db_cnt <= DB_RELOAD;
            end else if (db_cnt == '0) begin
               lvl    <= sync_2;
               db_cnt <= DB_RELOAD;
            end else begin
               db_cnt <= db_cnt - 1'b1;
            end
         end
      end

`ifdef AUTO_REPEAT_EN
      if (i != 0) begin : g_rep
         logic [RP_W-1:0] rep_cnt;
         logic            rep;

         // Arm on the press edge (same cycle prs is set), then fire every rate period while held.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               rep_cnt <= '0;
               rep     <= 1'b0;
            end else begin
               rep <= 1'b0;
               if (lvl & ~lvl_d) begin
                  rep_cnt <= RP_DLY_RELOAD;
               end else if (lvl) begin
                  if (rep_cnt == '0) begin
                     rep     <= 1'b1;
                     rep_cnt <= RP_RATE_RELOAD;
                  end else begin
                     rep_cnt <= rep_cnt - 1'b1;
                  end
               end
            end
         end

         assign pulse[i] = prs | rep;
      end else begin : g_norep
         assign pulse[i] = prs;
      end
`else
      assign pulse[i] = prs;
`endif
   end

   state_t          state;
   logic [TO_W-1:0] idle_cnt;
   logic            mode_ev;
   logic            inc_ev;
   logic            dec_ev;
   logic            any_ev;
   logic [4:0]      hrs_inc;
   logic [4:0]      hrs_dec;
   logic [5:0]      min_inc;
   logic [5:0]      min_dec;

   // MODE beats INC/DEC; INC together with DEC cancels out.
   assign mode_ev = pulse[0];
   assign inc_ev  = pulse[1] & ~pulse[2] & ~pulse[0];
   assign dec_ev  = pulse[2] & ~pulse[1] & ~pulse[0];
   assign any_ev  = |pulse;

   assign hrs_inc = (load_hrs == 5'd23) ? 5'd0  : load_hrs + 5'd1;
   assign hrs_dec = (load_hrs == 5'd0)  ? 5'd23 : load_hrs - 5'd1;
   assign min_inc = (load_min == 6'd59) ? 6'd0  : load_min + 6'd1;
   assign min_dec = (load_min == 6'd0)  ? 6'd59 : load_min - 6'd1;

   // Set-time FSM with registered outputs and idle timeout down-counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_RUN;
         load       <= 1'b0;
         load_hrs   <= 5'd0;
         load_min   <= 6'd0;
         set_active <= 1'b0;
         blink_sel  <= 2'b00;
         idle_cnt   <= '0;
      end else begin
         load <= 1'b0;
         case (state)
            S_RUN: begin
               if (mode_ev) begin
                  // Clamp so a glitched live value never seeds an out-of-range edit.
                  load_hrs   <= (cur_hrs > 5'd23) ? 5'd0 : cur_hrs;
                  load_min   <= (cur_min > 6'd59) ? 6'd0 : cur_min;
                  state      <= S_SET_HR;
                  set_active <= 1'b1;
                  blink_sel  <= 2'b01;
                  idle_cnt   <= TO_RELOAD;
               end
            end
            S_SET_HR: begin
               if (mode_ev) begin
                  state     <= S_SET_MIN;
                  blink_sel <= 2'b10;
                  idle_cnt  <= TO_RELOAD;
               end else if (any_ev) begin
                  idle_cnt <= TO_RELOAD;
                  if (inc_ev) begin
                     load_hrs <= hrs_inc;
                  end else if (dec_ev) begin
                     load_hrs <= hrs_dec;
                  end
               end else if (idle_cnt == '0) begin
                  state      <= S_RUN;
                  set_active <= 1'b0;
                  blink_sel  <= 2'b00;
               end else begin
                  idle_cnt <= idle_cnt - 1'b1;
               end
            end
            S_SET_MIN: begin
               if (mode_ev) begin
                  state      <= S_COMMIT;
                  load       <= 1'b1;
                  set_active <= 1'b0;
                  blink_sel  <= 2'b00;
               end else if (any_ev) begin
                  idle_cnt <= TO_RELOAD;
                  if (inc_ev) begin
                     load_min <= min_inc;
                  end else if (dec_ev) begin
                     load_min <= min_dec;
                  end
               end else if (idle_cnt == '0) begin
                  state      <= S_RUN;
                  set_active <= 1'b0;
                  blink_sel  <= 2'b00;
               end else begin
                  idle_cnt <= idle_cnt - 1'b1;
               end
            end
            S_COMMIT: begin
               state <= S_RUN;
            end
            default: begin
               state <= S_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with short timing parameters. A reference model of the
// clock-setting rules (modular hour/minute arithmetic) predicts every outcome.
module tb_time_set_ctrl;

   localparam int DB = 4;
   localparam int TO = 200;
   localparam int RD = 20;
   localparam int RR = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_dec = 1'b0;
   logic [4:0] cur_hrs = 5'd0;
   logic [5:0] cur_min = 6'd0;
   logic       load;
   logic [4:0] load_hrs;
   logic [5:0] load_min;
   logic [5:0] load_sec;
   logic       set_active;
   logic [1:0] blink_sel;

   time_set_ctrl #(
      .DB_CYCLES(DB),
      .TIMEOUT_CYCLES(TO),
      .REPEAT_DLY_CYCLES(RD),
      .REPEAT_RATE_CYCLES(RR)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_mode(btn_mode),
      .btn_inc(btn_inc),
      .btn_dec(btn_dec),
      .cur_hrs(cur_hrs),
      .cur_min(cur_min),
      .load(load),
      .load_hrs(load_hrs),
      .load_min(load_min),
      .load_sec(load_sec),
      .set_active(set_active),
      .blink_sel(blink_sel)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // Load monitor: counts cycles with load high and captures the loaded time.
   int load_cnt = 0;
   int cap_h = -1;
   int cap_m = -1;
   int cap_s = -1;
   always @(negedge clk) begin
      if (load === 1'b1) begin
         load_cnt = load_cnt + 1;
         cap_h = int'(load_hrs);
         cap_m = int'(load_min);
         cap_s = int'(load_sec);
      end
   end

   // Reference model: 0 = running, 1 = editing hours, 2 = editing minutes.
   int m_state = 0;
   int m_h = 0;
   int m_m = 0;
   int exp_loads = 0;
   int exp_h = 0;
   int exp_m = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_press(input bit m, input bit i, input bit d);
      if (m) begin
         if (m_state == 0) begin
            m_state = 1;
            m_h = int'(cur_hrs);
            m_m = int'(cur_min);
         end else if (m_state == 1) begin
            m_state = 2;
         end else begin
            m_state = 0;
            exp_loads++;
            exp_h = m_h;
            exp_m = m_m;
         end
      end else if (i && !d) begin
         if (m_state == 1) m_h = (m_h + 1) % 24;
         else if (m_state == 2) m_m = (m_m + 1) % 60;
      end else if (d && !i) begin
         if (m_state == 1) m_h = (m_h + 23) % 24;
         else if (m_state == 2) m_m = (m_m + 59) % 60;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".blink"}, 32'(blink_sel), 32'(m_state));
      check({tag, ".active"}, 32'(set_active), 32'(m_state != 0));
      if (m_state != 0) begin
         check({tag, ".hrs"}, 32'(load_hrs), 32'(m_h));
         check({tag, ".min"}, 32'(load_min), 32'(m_m));
      end
      check({tag, ".loads"}, 32'(load_cnt), 32'(exp_loads));
      if (exp_loads > 0 && load_cnt == exp_loads) begin
         check({tag, ".cap_h"}, 32'(cap_h), 32'(exp_h));
         check({tag, ".cap_m"}, 32'(cap_m), 32'(exp_m));
         check({tag, ".cap_s"}, 32'(cap_s), 32'd0);
      end
   endtask

   // One clean press (and release) of the chosen buttons, then model update and check.
   task automatic do_press(input bit m, input bit i, input bit d, input string tag);
      btn_mode = m;
      btn_inc  = i;
      btn_dec  = d;
      tick(DB + 6);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;
      tick(DB + 6);
      model_press(m, i, d);
      check_model(tag);
   endtask

   initial begin
      int n;
      int r;
      int rep_exp;

      // Reset values
      tick(3);
      check("rst.load", 32'(load), 32'd0);
      check("rst.hrs", 32'(load_hrs), 32'd0);
      check("rst.min", 32'(load_min), 32'd0);
      check("rst.sec", 32'(load_sec), 32'd0);
      check("rst.active", 32'(set_active), 32'd0);
      check("rst.blink", 32'(blink_sel), 32'd0);
      reset = 1'b1;
      tick(3);

      // Debounce: bouncing MODE, then a single press DB+3 cycles after the final rise
      cur_hrs = 5'd23;
      cur_min = 6'd58;
      btn_mode = 1'b1;
      tick(2);
      btn_mode = 1'b0;
      tick(2);
      btn_mode = 1'b1;
      tick(DB + 3);
      check("db.before_press", 32'(blink_sel), 32'd0);
      tick(1);
      check("db.after_press", 32'(blink_sel), 32'd1);
      tick(20);
      check("db.single_press", 32'(blink_sel), 32'd1);
      btn_mode = 1'b0;
      tick(DB + 6);
      model_press(1'b1, 1'b0, 1'b0);
      check_model("db");

      // Full edit from 23:58: INC, MODE, INC, INC, MODE -> 00:00
      do_press(1'b0, 1'b1, 1'b0, "fe.inc_hr");
      do_press(1'b1, 1'b0, 1'b0, "fe.mode_min");
      do_press(1'b0, 1'b1, 1'b0, "fe.inc_min1");
      do_press(1'b0, 1'b1, 1'b0, "fe.inc_min2");
      do_press(1'b1, 1'b0, 1'b0, "fe.commit");
      check("fe.load_h", 32'(cap_h), 32'd0);
      check("fe.load_m", 32'(cap_m), 32'd0);
      check("fe.load_cnt", 32'(load_cnt), 32'd1);

      // Wrap down from 00:00 -> 23:59
      cur_hrs = 5'd0;
      cur_min = 6'd0;
      do_press(1'b1, 1'b0, 1'b0, "wd.enter");
      do_press(1'b0, 1'b0, 1'b1, "wd.dec_hr");
      do_press(1'b1, 1'b0, 1'b0, "wd.mode_min");
      do_press(1'b0, 1'b0, 1'b1, "wd.dec_min");
      do_press(1'b1, 1'b0, 1'b0, "wd.commit");
      check("wd.load_h", 32'(cap_h), 32'd23);
      check("wd.load_m", 32'(cap_m), 32'd59);

      // Simultaneous presses
      cur_hrs = 5'd10;
      cur_min = 6'd20;
      do_press(1'b1, 1'b0, 1'b0, "sim.enter");
      do_press(1'b0, 1'b1, 1'b1, "sim.incdec_hr");
      do_press(1'b1, 1'b1, 1'b0, "sim.mode_inc");
      check("sim.in_min", 32'(blink_sel), 32'd2);
      check("sim.hrs_kept", 32'(load_hrs), 32'd10);
      do_press(1'b0, 1'b1, 1'b1, "sim.incdec_min");
      do_press(1'b1, 1'b0, 1'b0, "sim.commit");
      check("sim.load_h", 32'(cap_h), 32'd10);
      check("sim.load_m", 32'(cap_m), 32'd20);

      // INC held: debounced high for about 40 cycles past its press
      cur_hrs = 5'd5;
      cur_min = 6'd30;
      do_press(1'b1, 1'b0, 1'b0, "ar.enter");
      btn_inc = 1'b1;
      tick(42);
      btn_inc = 1'b0;
      tick(DB + 6);
`ifdef AUTO_REPEAT_EN
      rep_exp = 6;
`else
      rep_exp = 1;
`endif
      check("ar.hrs", 32'(load_hrs), 32'(5 + rep_exp));
      m_h = (m_h + rep_exp) % 24;
      do_press(1'b1, 1'b0, 1'b0, "ar.mode_min");
      do_press(1'b1, 1'b0, 1'b0, "ar.commit");

      // Randomised edit sessions against the model
      for (int s = 0; s < 5; s++) begin
         cur_hrs = 5'($urandom_range(0, 23));
         cur_min = 6'($urandom_range(0, 59));
         do_press(1'b1, 1'b0, 1'b0, "rnd.enter");
         for (int f = 0; f < 2; f++) begin
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
               r = $urandom_range(0, 2);
               do_press(1'b0, (r == 0) || (r == 2), (r == 1) || (r == 2), "rnd.adj");
            end
            do_press(1'b1, 1'b0, 1'b0, "rnd.mode");
         end
      end

      // Timeout: INC in SET_HR, then stay idle until the edit is abandoned
      cur_hrs = 5'd7;
      cur_min = 6'd45;
      do_press(1'b1, 1'b0, 1'b0, "to.enter");
      do_press(1'b0, 1'b1, 1'b0, "to.inc");
      tick(185);
      check("to.still_edit", 32'(set_active), 32'd1);
      tick(7);
      m_state = 0;
      check_model("to.back_run");
      tick(20);
      check("to.no_load", 32'(load_cnt), 32'(exp_loads));

      // Reset mid-SET_MIN aborts the edit at once
      cur_hrs = 5'd12;
      cur_min = 6'd34;
      do_press(1'b1, 1'b0, 1'b0, "rm.enter");
      do_press(1'b1, 1'b0, 1'b0, "rm.mode_min");
      reset = 1'b0;
      #1;
      check("rm.load", 32'(load), 32'd0);
      check("rm.hrs", 32'(load_hrs), 32'd0);
      check("rm.min", 32'(load_min), 32'd0);
      check("rm.active", 32'(set_active), 32'd0);
      check("rm.blink", 32'(blink_sel), 32'd0);
      tick(3);
      reset = 1'b1;
      tick(30);
      m_state = 0;
      check_model("rm.after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
